// File: rtl/fft_loader_pkg.sv
// Purpose: shared types and frame geometry for the FFT ADC capture loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fft_loader_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        LAUNCH   = 2'd2,
        WAIT_FFT = 2'd3
    } state_t;

    // Default geometry, matching fft_top's four 512-word input banks
    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 9;
    localparam int N_BANKS_DEF = 4;

    // One frame fills every bank once
    localparam int N_POINTS = N_BANKS_DEF * (2 ** ADDR_W_DEF);

    // Sample counter: upper bits select the bank, lower bits the word address
    localparam int CNT_W = $clog2(N_POINTS);

endpackage

// File: rtl/fft_adc_loader.sv
// Purpose: capture one 2048-sample ADC frame into fft_top's four input banks, then launch the FFT.
// Latency: sample accepted at cycle t is written at t+1; oSTART at t+2 after the last write.
// Backpressure: none; samples in LAUNCH/WAIT_FFT are dropped and flagged on sticky oOVF.
// Option: define FFT_LOADER_OFFSET_BIN_EN to treat iADC_DATA as offset-binary (MSB inverted).
module fft_adc_loader
    import fft_loader_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int N_BANKS = N_BANKS_DEF
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iADC_DATA,
    input  logic              iADC_VALID,
    input  logic              iARM,
    input  logic              iCONT,
    input  logic              iCLR_OVF,
    input  logic              iRDY,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic              oOVF
);

    localparam int BANK_W   = $clog2(N_BANKS);
    localparam int CNT_BITS = ADDR_W + BANK_W;

    // Frame length is a power of two, so the final sample index is all ones
    localparam logic [CNT_BITS-1:0] LAST_CNT = '1;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data_in;
    logic                rdy_q;
    logic                ovf_set;
    logic [N_BANKS-1:0]  we_q;
    logic [ADDR_W-1:0]   addr_q [N_BANKS];

    // Bank select and word address come straight from the sample counter
    assign bank = cnt[CNT_BITS-1:ADDR_W];
    assign addr = cnt[ADDR_W-1:0];

`ifdef FFT_LOADER_OFFSET_BIN_EN
    // Offset-binary to two's complement is a single MSB flip: 8000h -> 0, 0000h -> most negative
    assign data_in = {~iADC_DATA[DATA_W-1], iADC_DATA[DATA_W-2:0]};
`else
    // ADC already delivers two's complement; pass straight through
    assign data_in = iADC_DATA;
`endif

    // Any sample arriving after the frame is full but before the FFT hands back is lost
    assign ovf_set = iADC_VALID && ((state == LAUNCH) || (state == WAIT_FFT));

    // Capture FSM with registered write strobes, start and done pulses
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            rdy_q       <= 1'b0;
            oDATA       <= '0;
            we_q        <= '0;
            oSTART      <= 1'b0;
            oFRAME_DONE <= 1'b0;
            for (int b = 0; b < N_BANKS; b++) begin
                addr_q[b] <= '0;
            end
        end else begin
            // Strobes are single-cycle unless re-asserted below
            we_q        <= '0;
            oSTART      <= 1'b0;
            oFRAME_DONE <= 1'b0;
            rdy_q       <= iRDY;

            case (state)
                IDLE: begin
                    // A sample coincident with the arm/continue request is not part of the frame
                    if (iARM || iCONT) begin
                        state <= FILL;
                    end
                end

                FILL: begin
                    if (iADC_VALID) begin
                        oDATA        <= data_in;
                        addr_q[bank] <= addr;
                        we_q[bank]   <= 1'b1;
                        if (cnt == LAST_CNT) begin
                            cnt   <= '0;
                            state <= LAUNCH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                LAUNCH: begin
                    // One cycle gap lets the last bank write land before the FFT starts
                    oSTART <= 1'b1;
                    state  <= WAIT_FFT;
                end

                WAIT_FFT: begin
                    // Only a fresh rising edge of iRDY counts; a level held from before is stale
                    if (iRDY && !rdy_q) begin
                        oFRAME_DONE <= 1'b1;
                        state       <= iCONT ? FILL : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow flag; a new drop outranks a simultaneous clear
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oOVF <= 1'b0;
        end else if (ovf_set) begin
            oOVF <= 1'b1;
        end else if (iCLR_OVF) begin
            oOVF <= 1'b0;
        end
    end

    assign oBUSY = (state != IDLE);

    assign oWE_0 = we_q[0];
    assign oWE_1 = we_q[1];
    assign oWE_2 = we_q[2];
    assign oWE_3 = we_q[3];

    assign oADDR_WR_0 = addr_q[0];
    assign oADDR_WR_1 = addr_q[1];
    assign oADDR_WR_2 = addr_q[2];
    assign oADDR_WR_3 = addr_q[3];

endmodule

// File: tb/tb_fft_adc_loader.sv
// Purpose: directed self-checking bench for fft_adc_loader with a bank-RAM image model.
// Latency: checks write at t+1 after acceptance and oSTART one cycle after the last write.
// Backpressure: checks drop-and-flag overflow in LAUNCH/WAIT_FFT and silent ignore in IDLE.
module tb_fft_adc_loader;
    import fft_loader_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic [15:0] iADC_DATA;
    logic        iADC_VALID;
    logic        iARM;
    logic        iCONT;
    logic        iCLR_OVF;
    logic        iRDY;
    logic [15:0] oDATA;
    logic [8:0]  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic        oWE_0, oWE_1, oWE_2, oWE_3;
    logic        oSTART, oBUSY, oFRAME_DONE, oOVF;

    always #5 iCLK = ~iCLK;

    fft_adc_loader dut (
        .iCLK(iCLK), .iRESET(iRESET), .iADC_DATA(iADC_DATA), .iADC_VALID(iADC_VALID),
        .iARM(iARM), .iCONT(iCONT), .iCLR_OVF(iCLR_OVF), .iRDY(iRDY),
        .oDATA(oDATA),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
        .oSTART(oSTART), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oOVF(oOVF)
    );

    int total = 0;
    int bad   = 0;

    // fft_top input-bank image and write statistics, sampled on the falling edge
    logic [15:0] mem [N_POINTS];
    int cyc = 0, wr_cnt = 0, multi = 0, start_cnt = 0, done_cnt = 0;
    int last_wr_cyc = 0, start_cyc = 0, last_b = 0, last_a = 0;

    always @(negedge iCLK) begin
        logic [3:0] w;
        logic [8:0] a [4];
        cyc++;
        w    = {oWE_3, oWE_2, oWE_1, oWE_0};
        a[0] = oADDR_WR_0;
        a[1] = oADDR_WR_1;
        a[2] = oADDR_WR_2;
        a[3] = oADDR_WR_3;
        if ($countones(w) > 1) multi++;
        for (int b = 0; b < 4; b++) begin
            if (w[b]) begin
                mem[b * 512 + int'(a[b])] = oDATA;
                wr_cnt++;
                last_wr_cyc = cyc;
                last_b = b;
                last_a = int'(a[b]);
            end
        end
        if (oSTART) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (oFRAME_DONE) done_cnt++;
    end

    function automatic logic [15:0] xform(input logic [15:0] d);
`ifdef FFT_LOADER_OFFSET_BIN_EN
        return {~d[15], d[14:0]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        iADC_VALID = 1'b1;
        iADC_DATA  = d;
        step();
        iADC_VALID = 1'b0;
    endtask

    task automatic clear_stats();
        wr_cnt = 0; multi = 0; start_cnt = 0; done_cnt = 0;
        for (int i = 0; i < N_POINTS; i++) mem[i] = 16'hDEAD;
    endtask

    task automatic check_ramp_image(input string name);
        int errs = 0;
        for (int n = 0; n < N_POINTS; n++) begin
            if (mem[n] !== xform(16'(n))) errs++;
        end
        chk(name, errs, 0);
    endtask

    task automatic wait_start();
        int n = 0;
        while (oSTART !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk("start_seen", {31'd0, oSTART}, 1);
    endtask

    task automatic done_pulse(input int gap);
        repeat (gap) step();
        iRDY = 1'b1;
        step();
        chk("frame_done", {31'd0, oFRAME_DONE}, 1);
        iRDY = 1'b0;
        step();
        chk("done_single", {31'd0, oFRAME_DONE}, 0);
    endtask

    function automatic logic [31:0] all_outs();
        return {oWE_3, oWE_2, oWE_1, oWE_0, oSTART, oBUSY, oFRAME_DONE, oOVF} |
               32'(oDATA) | 32'(oADDR_WR_0) | 32'(oADDR_WR_1) |
               32'(oADDR_WR_2) | 32'(oADDR_WR_3);
    endfunction

    typedef struct {
        logic        vld;
        logic [15:0] din;
        logic [3:0]  we;
        logic [8:0]  addr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int nacc;
        int w0;

        tbl[0] = '{1'b1, 16'h0000, 4'b0001, 9'd0};
        tbl[1] = '{1'b1, 16'h7FFF, 4'b0001, 9'd1};
        tbl[2] = '{1'b0, 16'h5555, 4'b0000, 9'd0};
        tbl[3] = '{1'b1, 16'h8000, 4'b0001, 9'd2};
        tbl[4] = '{1'b1, 16'hFFFF, 4'b0001, 9'd3};
        tbl[5] = '{1'b0, 16'h1111, 4'b0000, 9'd0};
        tbl[6] = '{1'b0, 16'h2222, 4'b0000, 9'd0};
        tbl[7] = '{1'b1, 16'h1234, 4'b0001, 9'd4};
        tbl[8] = '{1'b1, 16'hA5A5, 4'b0001, 9'd5};

        // Reset held with random inputs: everything stays zero
        iRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iADC_DATA  = 16'($urandom);
            iADC_VALID = 1'($urandom);
            iARM       = 1'($urandom);
            iCONT      = 1'($urandom);
            iCLR_OVF   = 1'($urandom);
            iRDY       = 1'($urandom);
            step();
            chk("reset_outs", all_outs(), 0);
        end
        iADC_DATA = '0; iADC_VALID = 0; iARM = 0; iCONT = 0; iCLR_OVF = 0; iRDY = 0;
        iRESET = 1'b1;
        step();
        step();
        chk("idle_busy", {31'd0, oBUSY}, 0);
        chk("idle_outs", all_outs(), 0);

        // Table-driven start of a frame: data patterns, gaps, address progression
        clear_stats();
        iARM = 1'b1;
        step();
        iARM = 1'b0;
        chk("armed_busy", {31'd0, oBUSY}, 1);
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            iADC_VALID = tbl[i].vld;
            iADC_DATA  = tbl[i].din;
            step();
            iADC_VALID = 1'b0;
            chk($sformatf("tbl%0d_we", i), {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, {28'd0, tbl[i].we});
            if (tbl[i].vld) begin
                nacc++;
                chk($sformatf("tbl%0d_addr", i), {23'd0, oADDR_WR_0}, {23'd0, tbl[i].addr});
                chk($sformatf("tbl%0d_data", i), {16'd0, oDATA}, {16'd0, xform(tbl[i].din)});
            end
        end
        for (int n = nacc; n < N_POINTS; n++) send(16'(n));
        wait_start();
        done_pulse(3);
        chk("tbl_idle_after", {31'd0, oBUSY}, 0);

        // Single-shot ramp, back-to-back samples
        clear_stats();
        iARM = 1'b1;
        step();
        iARM = 1'b0;
        for (int n = 0; n < N_POINTS; n++) send(16'(n));
        chk("ramp_no_early_start", {31'd0, oSTART}, 0);
        step();
        chk("ramp_start", {31'd0, oSTART}, 1);
        step();
        chk("ramp_start_len", {31'd0, oSTART}, 0);
        check_ramp_image("ramp_image");
        chk("ramp_wr_cnt", wr_cnt, N_POINTS);
        chk("ramp_onehot", multi, 0);
        chk("ramp_last_loc", last_b * 512 + last_a, N_POINTS - 1);
        chk("ramp_start_cnt", start_cnt, 1);
        chk("ramp_start_gap", start_cyc - last_wr_cyc, 1);

        // Overflow while waiting for the FFT
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) send(16'h4000 + 16'(i));
        step();
        chk("ovf_no_we", wr_cnt, w0);
        chk("ovf_set", {31'd0, oOVF}, 1);
        iCLR_OVF = 1'b1;
        step();
        iCLR_OVF = 1'b0;
        chk("ovf_clear", {31'd0, oOVF}, 0);
        iCLR_OVF = 1'b1;
        iADC_VALID = 1'b1;
        step();
        iCLR_OVF = 1'b0;
        iADC_VALID = 1'b0;
        chk("ovf_set_wins", {31'd0, oOVF}, 1);
        iCLR_OVF = 1'b1;
        step();
        iCLR_OVF = 1'b0;
        chk("ovf_clear2", {31'd0, oOVF}, 0);
        done_pulse(2);
        chk("single_to_idle", {31'd0, oBUSY}, 0);

        // Samples in IDLE are ignored and do not flag overflow
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) send(16'h0F0F);
        step();
        chk("idle_no_we", wr_cnt, w0);
        chk("idle_no_ovf", {31'd0, oOVF}, 0);

        // Gapped input: valid one cycle in three
        clear_stats();
        iARM = 1'b1;
        step();
        iARM = 1'b0;
        for (int n = 0; n < N_POINTS; n++) begin
            send(16'(n));
            if (n != N_POINTS - 1) begin
                step();
                step();
            end
        end
        step();
        chk("gap_start", {31'd0, oSTART}, 1);
        step();
        check_ramp_image("gap_image");
        chk("gap_wr_cnt", wr_cnt, N_POINTS);
        chk("gap_start_gap", start_cyc - last_wr_cyc, 1);
        done_pulse(4);

        // Continuous mode: two frames, no arm
        clear_stats();
        iCONT = 1'b1;
        step();
        for (int n = 0; n < N_POINTS; n++) send(16'(n));
        wait_start();
        done_pulse(99);
        chk("cont_still_busy", {31'd0, oBUSY}, 1);
        send(16'h0ABC);
        chk("cont_first_we", {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, 32'b0001);
        chk("cont_first_addr", {23'd0, oADDR_WR_0}, 0);
        for (int n = 1; n < N_POINTS; n++) send(16'(n));
        iCONT = 1'b0;
        wait_start();
        done_pulse(10);
        chk("cont_end_idle", {31'd0, oBUSY}, 0);
        step();
        chk("cont_done_cnt", done_cnt, 2);
        chk("cont_start_cnt", start_cnt, 2);
        chk("cont_wr_cnt", wr_cnt, 2 * N_POINTS);

        // Reset in the middle of a fill
        iARM = 1'b1;
        step();
        iARM = 1'b0;
        for (int n = 0; n < 700; n++) send(16'(n));
        iRESET = 1'b0;
        #1;
        chk("midreset_outs", all_outs(), 0);
        step();
        iRESET = 1'b1;
        step();
        clear_stats();
        iARM = 1'b1;
        step();
        iARM = 1'b0;
        send(16'd0);
        chk("rearm_we", {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, 32'b0001);
        chk("rearm_addr", {23'd0, oADDR_WR_0}, 0);
        for (int n = 1; n < N_POINTS; n++) send(16'(n));
        step();
        chk("rearm_start", {31'd0, oSTART}, 1);
        step();
        chk("rearm_start_cnt", start_cnt, 1);
        check_ramp_image("rearm_image");
        done_pulse(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
